// File: rtl/sumador_acumulador_if.sv
// Frame bus between the multiplier stage and the accumulator: offset/start,
// product beats, and the registered frame result with its overflow flag.
interface sumador_acumulador_if #(
  parameter int W = 49
);
  logic                start;
  logic signed [W-1:0] Sum_ext;
  logic                in_valid;
  logic signed [W-1:0] Multiplica;
  logic                in_ready;
  logic signed [W-1:0] Suma_G;
  logic                out_valid;
  logic                ovf;

  modport master (
    output start, Sum_ext, in_valid, Multiplica,
    input  in_ready, Suma_G, out_valid, ovf
  );

  modport slave (
    input  start, Sum_ext, in_valid, Multiplica,
    output in_ready, Suma_G, out_valid, ovf
  );
endinterface

// File: rtl/sumador_acumulador.sv
// Frame accumulator: loads an offset on start, adds TAPS signed products, then
// pulses out_valid with the registered sum. SUMADOR_SAT_EN selects saturation.
module sumador_acumulador #(
  parameter int N    = 25,
  parameter int TAPS = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  sumador_acumulador_if.slave  bus
);
  localparam int W  = 2*N-1;
  localparam int CW = $clog2(TAPS)+1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACUM = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic signed [W-1:0] acc_q, acc_d;
  logic        [CW-1:0] count_q, count_d;
  logic signed [W-1:0] suma_q, suma_d;
  logic                outv_q, outv_d;
  logic                ovf_q, ovf_d;

  logic        [W:0]   sum_full;
  logic                pos_ovf, neg_ovf;
  logic signed [W-1:0] step_val;

  // Exact sum one bit wider; the top two bits disagree exactly on overflow.
  assign sum_full = {acc_q[W-1], acc_q} + {bus.Multiplica[W-1], bus.Multiplica};
  assign pos_ovf  = ~sum_full[W] &  sum_full[W-1];
  assign neg_ovf  =  sum_full[W] & ~sum_full[W-1];

`ifdef SUMADOR_SAT_EN
  localparam logic [W-1:0] MAXV = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] MINV = {1'b1, {(W-1){1'b0}}};

  always_comb begin
    step_val = sum_full[W-1:0];
    if (pos_ovf)      step_val = MAXV;
    else if (neg_ovf) step_val = MINV;
  end
`else
  assign step_val = sum_full[W-1:0];
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      acc_q   <= '0;
      count_q <= '0;
      suma_q  <= '0;
      outv_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      count_q <= count_d;
      suma_q  <= suma_d;
      outv_q  <= outv_d;
      ovf_q   <= ovf_d;
    end
  end

  // A start in ACUM restarts the frame and wins over a beat on the same cycle.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    count_d = count_q;
    suma_d  = suma_q;
    outv_d  = 1'b0;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          acc_d   = bus.Sum_ext;
          count_d = '0;
          ovf_d   = 1'b0;
          state_d = ACUM;
        end
      end
      ACUM: begin
        if (bus.start) begin
          acc_d   = bus.Sum_ext;
          count_d = '0;
          ovf_d   = 1'b0;
        end else if (bus.in_valid) begin
          acc_d   = step_val;
          count_d = count_q + CW'(1);
          if (pos_ovf || neg_ovf) ovf_d = 1'b1;
          if (count_q == CW'(TAPS-1)) begin
            suma_d  = step_val;
            outv_d  = 1'b1;
            state_d = DONE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.in_ready  = (state_q == ACUM);
  assign bus.Suma_G    = suma_q;
  assign bus.out_valid = outv_q;
  assign bus.ovf       = ovf_q;
endmodule
